fetch_sequencer: RTL and testbench

- Instruction-fetch front end for the S1C88 core. Reads instruction bytes over the 8-bit memory bus and assembles each instruction: opcode, optional CE/CF extension byte, and an 8- or 16-bit immediate.
- It is the producer side of the opcode decoder. It drives the decoder's opcode/opext inputs and consumes need_opext / need_imm / imm_size to choose how many bytes to fetch.
- A complete instruction is handed to the execute stage with a valid/ready handshake.

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: pulls opcode, optional extension and immediate
// bytes over an 8-bit bus and presents the assembled instruction to execute.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_rdata,
  output logic [7:0]            dec_opcode,
  output logic [7:0]            dec_opext,
  input  logic                  need_opext,
  input  logic                  need_imm,
  input  logic                  imm_size,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic [7:0]            instr_opext,
  output logic [15:0]           instr_imm,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [2:0]            instr_len,
  output logic [2:0]            dbg_state
);

  // Handshakes: a bus byte is consumed in any cycle with bus_req & bus_ack;
  // an instruction transfers in any cycle with instr_valid & instr_ready,
  // unless redirect is also high, in which case nothing transfers.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    F_OP     = 3'd1,
    F_EXT    = 3'd2,
    F_IMM_LO = 3'd3,
    F_IMM_HI = 3'd4,
    HOLD     = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [7:0]            opext_q, opext_d;
  logic [15:0]           imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic [2:0]            len_q, len_d;
  logic                  ack;
  logic [2:0]            imm_bytes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      opcode_q <= 8'h00;
      opext_q  <= 8'h00;
      imm_q    <= 16'h0000;
      ipc_q    <= '0;
      len_q    <= 3'd1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      opext_q  <= opext_d;
      imm_q    <= imm_d;
      ipc_q    <= ipc_d;
      len_q    <= len_d;
    end
  end

  // Bus outputs come from registered state only, never from bus_ack.
  assign bus_req   = (state_q == F_OP) || (state_q == F_EXT) ||
                     (state_q == F_IMM_LO) || (state_q == F_IMM_HI);
  assign bus_addr  = pc_q;
  assign ack       = bus_req & bus_ack;
  assign dbg_state = state_q;

  assign instr_valid  = (state_q == HOLD);
  assign instr_opcode = opcode_q;
  assign instr_opext  = opext_q;
  assign instr_imm    = imm_q;
  assign instr_pc     = ipc_q;
  assign instr_len    = len_q;

  // The decoder sees the byte in its ack cycle so the next state needs no bubble.
  assign dec_opcode = ((state_q == F_OP) && bus_ack) ? bus_rdata : opcode_q;
  assign dec_opext  = ((state_q == F_EXT) && bus_ack) ? bus_rdata : opext_q;

  assign imm_bytes = {2'b00, need_imm} + {2'b00, need_imm & imm_size};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    opext_d  = opext_q;
    imm_d    = imm_q;
    ipc_d    = ipc_q;
    len_d    = len_q;

    if (redirect) begin
      // Any byte acked this cycle and any pending instruction are dropped.
      state_d = F_OP;
      pc_d    = redirect_pc;
      opext_d = 8'h00;
      imm_d   = 16'h0000;
    end else begin
      case (state_q)
        F_OP: begin
          if (ack) begin
            pc_d     = pc_q + 1'b1;
            opcode_d = bus_rdata;
            ipc_d    = pc_q;
            if (need_opext) begin
              len_d   = 3'd2;
              state_d = F_EXT;
            end else if (need_imm) begin
              len_d   = 3'd1 + imm_bytes;
              state_d = F_IMM_LO;
            end else begin
              len_d   = 3'd1;
              state_d = HOLD;
            end
          end
        end
        F_EXT: begin
          if (ack) begin
            pc_d    = pc_q + 1'b1;
            opext_d = bus_rdata;
            len_d   = len_q + imm_bytes;
            state_d = need_imm ? F_IMM_LO : HOLD;
          end
        end
        F_IMM_LO: begin
          if (ack) begin
            pc_d       = pc_q + 1'b1;
            imm_d[7:0] = bus_rdata;
            state_d    = imm_size ? F_IMM_HI : HOLD;
          end
        end
        F_IMM_HI: begin
          if (ack) begin
            pc_d        = pc_q + 1'b1;
            imm_d[15:8] = bus_rdata;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            opext_d = 8'h00;
            imm_d   = 16'h0000;
            state_d = F_OP;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM-backed bus with programmable wait,
// small decoder model, transfer counter, immediate assertions per check.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        redirect;
  logic [23:0] redirect_pc;
  logic        bus_req;
  logic [23:0] bus_addr;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic [7:0]  dec_opcode;
  logic [7:0]  dec_opext;
  logic        need_opext;
  logic        need_imm;
  logic        imm_size;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_opext;
  logic [15:0] instr_imm;
  logic [23:0] instr_pc;
  logic [2:0]  instr_len;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int exp_xfer = 0;
  int n_cyc;

  logic       ack_en;
  int         wait_cfg;
  int         wait_cnt;

  fetch_sequencer #(.ADDR_WIDTH(24)) dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dec_opcode(dec_opcode), .dec_opext(dec_opext), .need_opext(need_opext),
    .need_imm(need_imm), .imm_size(imm_size), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_opext(instr_opext),
    .instr_imm(instr_imm), .instr_pc(instr_pc), .instr_len(instr_len),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus memory and decoder model ----------------
  function automatic logic [7:0] rom(input logic [23:0] a);
    case (a)
      24'h000100: rom = 8'h00;
      24'h000200: rom = 8'hC4;
      24'h000201: rom = 8'h34;
      24'h000202: rom = 8'h12;
      24'h000300: rom = 8'h00;
      24'h000400: rom = 8'hCE;
      24'h000401: rom = 8'hD0;
      24'h000402: rom = 8'h78;
      24'h000403: rom = 8'h56;
      24'h000404: rom = 8'hCE;
      24'h000405: rom = 8'h02;
      24'h000406: rom = 8'h02;
      24'h000407: rom = 8'hAB;
      24'h000500: rom = 8'h02;
      24'h000501: rom = 8'h5A;
      24'h000600: rom = 8'hC4;
      24'h000601: rom = 8'h11;
      24'h000602: rom = 8'h22;
      24'hFFFFFF: rom = 8'hC4;
      24'h000000: rom = 8'h11;
      24'h000001: rom = 8'h22;
      default:    rom = 8'h00;
    endcase
  endfunction

  assign bus_rdata = rom(bus_addr);
  assign bus_ack   = ack_en && bus_req && (wait_cnt >= wait_cfg);

  always @(posedge clk) begin
    if (!bus_req || bus_ack || redirect) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  wire ext_op = (dec_opcode == 8'hCE) || (dec_opcode == 8'hCF);
  assign need_opext = ext_op;
  assign need_imm   = ext_op ? (dec_opext == 8'hD0)
                             : ((dec_opcode == 8'hC4) || (dec_opcode == 8'h02));
  assign imm_size   = ext_op ? (dec_opext == 8'hD0) : (dec_opcode == 8'hC4);

  always @(posedge clk) begin
    if (reset_n && instr_valid && instr_ready && !redirect) xfer_cnt <= xfer_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps at least once, then until instr_valid or the budget runs out.
  task automatic wait_next(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!instr_valid && n < max);
    chk("valid_timeout", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic do_redirect(input logic [23:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] ext,
                           input logic [15:0] imm, input logic [23:0] pc, input logic [2:0] len);
    chk({tag, "_op"},  {24'b0, instr_opcode}, {24'b0, op});
    chk({tag, "_ext"}, {24'b0, instr_opext},  {24'b0, ext});
    chk({tag, "_imm"}, {16'b0, instr_imm},    {16'b0, imm});
    chk({tag, "_pc"},  {8'b0, instr_pc},      {8'b0, pc});
    chk({tag, "_len"}, {29'b0, instr_len},    {29'b0, len});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 24'h0;
    instr_ready = 1'b0;
    ack_en      = 1'b0;
    wait_cfg    = 0;
    step();
    step();
    chk("rst_req",   {31'b0, bus_req},     32'd0);
    chk("rst_addr",  {8'b0, bus_addr},     32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_state", {29'b0, dbg_state},   32'd0);
    chk_instr("rst", 8'h00, 8'h00, 16'h0000, 24'h0, 3'd1);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    step();
    step();
    step();
    chk("idle_noreq", {31'b0, bus_req}, 32'd0);

    // Single-byte NOP at 0x100
    do_redirect(24'h000100);
    chk("t1_addr", {8'b0, bus_addr}, 32'h100);
    chk("t1_req",  {31'b0, bus_req}, 32'd1);
    wait_next(10, n_cyc);
    chk("t1_lat", n_cyc, 32'd1);
    chk_instr("t1", 8'h00, 8'h00, 16'h0000, 24'h000100, 3'd1);
    chk("t1_next", {8'b0, bus_addr}, 32'h101);
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    step();
    exp_xfer++;
    chk("t1_xfer",   xfer_cnt, exp_xfer);
    chk("t1_nvalid", {31'b0, instr_valid}, 32'd0);
    chk("t1_fetch",  {8'b0, bus_addr}, 32'h101);

    // C4 34 12: imm16, valid three cycles after the first ack
    instr_ready = 1'b0;
    ack_en      = 1'b1;
    do_redirect(24'h000200);
    chk("t2_decop", {24'b0, dec_opcode}, 32'hC4);
    wait_next(10, n_cyc);
    chk("t2_lat", n_cyc, 32'd3);
    chk_instr("t2", 8'hC4, 8'h00, 16'h1234, 24'h000200, 3'd3);
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    step();
    exp_xfer++;
    chk("t2_xfer", xfer_cnt, exp_xfer);

    // Back-to-back CE D0 78 56 / CE 02 / 02 AB with ready high
    ack_en = 1'b1;
    do_redirect(24'h000400);
    wait_next(10, n_cyc);
    chk("t3a_lat", n_cyc, 32'd4);
    chk_instr("t3a", 8'hCE, 8'hD0, 16'h5678, 24'h000400, 3'd4);
    wait_next(10, n_cyc);
    chk("t3b_lat", n_cyc, 32'd3);
    chk_instr("t3b", 8'hCE, 8'h02, 16'h0000, 24'h000404, 3'd2);
    wait_next(10, n_cyc);
    chk("t3c_lat", n_cyc, 32'd3);
    chk_instr("t3c", 8'h02, 8'h00, 16'h00AB, 24'h000406, 3'd2);
    ack_en = 1'b0;
    step();
    exp_xfer += 3;
    chk("t3_xfer", xfer_cnt, exp_xfer);

    // Three wait states per byte; execute stalls five cycles in HOLD
    instr_ready = 1'b0;
    ack_en      = 1'b1;
    wait_cfg    = 3;
    do_redirect(24'h000500);
    for (int i = 0; i < 3; i++) begin
      chk("t4_req",  {31'b0, bus_req}, 32'd1);
      chk("t4_addr", {8'b0, bus_addr}, 32'h500);
      step();
    end
    chk("t4_ackaddr", {8'b0, bus_addr}, 32'h500);
    wait_next(20, n_cyc);
    chk("t4_lat", n_cyc, 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("t4_hold_req",   {31'b0, bus_req}, 32'd0);
      chk_instr("t4_hold", 8'h02, 8'h00, 16'h005A, 24'h000500, 3'd2);
      step();
    end
    chk("t4_noxfer", xfer_cnt, exp_xfer);
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    step();
    exp_xfer++;
    chk("t4_xfer", xfer_cnt, exp_xfer);
    step();
    chk("t4_once", xfer_cnt, exp_xfer);
    chk("t4_nvalid", {31'b0, instr_valid}, 32'd0);

    // Redirect while an F_IMM_LO ack is in flight
    wait_cfg    = 0;
    ack_en      = 1'b1;
    instr_ready = 1'b0;
    do_redirect(24'h000600);
    step();
    chk("t5_state_lo", {29'b0, dbg_state}, 32'd3);
    chk("t5_ack",      {31'b0, bus_ack},   32'd1);
    do_redirect(24'h000300);
    chk("t5_addr",   {8'b0, bus_addr},     32'h300);
    chk("t5_nvalid", {31'b0, instr_valid}, 32'd0);
    wait_next(10, n_cyc);
    chk("t5_lat", n_cyc, 32'd1);
    chk_instr("t5", 8'h00, 8'h00, 16'h0000, 24'h000300, 3'd1);
    chk("t5_noxfer", xfer_cnt, exp_xfer);

    // Redirect and ready together in HOLD: instruction dropped
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    do_redirect(24'h000700);
    chk("t5_drop",     xfer_cnt, exp_xfer);
    chk("t5_dropaddr", {8'b0, bus_addr}, 32'h700);
    chk("t5_dropvld",  {31'b0, instr_valid}, 32'd0);

    // PC wrap inside an instruction
    instr_ready = 1'b0;
    ack_en      = 1'b1;
    do_redirect(24'hFFFFFF);
    chk("t6_addr0", {8'b0, bus_addr}, 32'hFFFFFF);
    step();
    chk("t6_addr1", {8'b0, bus_addr}, 32'h000000);
    step();
    chk("t6_addr2", {8'b0, bus_addr}, 32'h000001);
    step();
    chk("t6_valid", {31'b0, instr_valid}, 32'd1);
    chk_instr("t6", 8'hC4, 8'h00, 16'h2211, 24'hFFFFFF, 3'd3);
    chk("t6_next", {8'b0, bus_addr}, 32'h000002);
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    step();
    exp_xfer++;
    chk("t6_xfer", xfer_cnt, exp_xfer);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
